// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mult/div opcode encoding, busy-FSM states and
// default unit latencies used by the hazard scheduler.
package cpu_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hazard_sched_md_busy_ctr.sv
// HI/LO unit occupancy tracker: counts down the mult/div latency after a start
// and reports md_busy while the unit is occupied.
module md_busy_ctr
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_md_start,
  input  logic [1:0] ex_md_op,
  output logic       md_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  md_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  // A start while BUSY is dropped: the decode stall keeps it from happening.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_md_start) begin
            cnt_q   <= md_is_div(ex_md_op) ? DIV_LOAD : MULT_LOAD;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = busy_q & ~rst;

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use and mult/div stalls plus interrupt flush
// for PC, IF/ID and ID/EX. Optional HAZ_STATS_EN adds stall/flush counters.
module hazard_sched
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_md,
  input  logic        ex_load,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_md_start,
  input  logic [1:0]  ex_md_op,
  input  logic        int_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        int_ack,
  output logic        md_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic md_busy_w;
  logic load_stall;
  logic md_stall;
  logic stall;
  logic accept;
  logic int_pend_q, int_pend_d;

  md_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk        (clk),
    .rst        (rst),
    .ex_md_start(ex_md_start),
    .ex_md_op   (ex_md_op),
    .md_busy    (md_busy_w)
  );

  // Reset masks every hazard so the pipeline free-runs; an accepted interrupt
  // then wins over any stall.
  always_comb begin
    load_stall = ~rst & ex_load & (ex_wr_reg != 5'd0) &
                 ((id_use_rs & (id_rs == ex_wr_reg)) |
                  (id_use_rt & (id_rt == ex_wr_reg)));
    md_stall   = ~rst & id_md & (md_busy_w | ex_md_start);
    stall      = load_stall | md_stall;
    accept     = ~rst & int_req & ~int_pend_q;

    int_pend_d = int_pend_q;
    if (accept) begin
      int_pend_d = 1'b1;
    end else if (!int_req) begin
      int_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_pend_q <= 1'b0;
    end else begin
      int_pend_q <= int_pend_d;
    end
  end

  assign pc_en       = accept | ~stall;
  assign if_id_en    = accept | ~stall;
  assign id_ex_en    = accept | ~stall;
  assign if_id_flush = accept;
  assign id_ex_flush = accept;
  assign int_ack     = accept;
  assign md_busy     = md_busy_w;

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Stall cycles absorbed by an interrupt accept are not counted as stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !accept) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (accept) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed per-cycle vectors push expected
// control words; a negedge monitor pops and compares them.
module tb_hazard_sched;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_wr_reg = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_md = 1'b0, ex_load = 1'b0;
  logic       ex_md_start = 1'b0, int_req = 1'b0;
  logic [1:0] ex_md_op = '0;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, int_ack, md_busy;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] snapA, snapB;
`endif

  always #5 clk = ~clk;

  hazard_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md(id_md), .ex_load(ex_load), .ex_wr_reg(ex_wr_reg),
    .ex_md_start(ex_md_start), .ex_md_op(ex_md_op), .int_req(int_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .int_ack(int_ack),
    .md_busy(md_busy)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Control word: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, int_ack, md_busy}
  localparam logic [6:0] RUN  = 7'b1110000;
  localparam logic [6:0] RUNB = 7'b1110001;
  localparam logic [6:0] STL  = 7'b0000000;
  localparam logic [6:0] STLB = 7'b0000001;
  localparam logic [6:0] ACK  = 7'b1111110;
  localparam logic [6:0] ACKB = 7'b1111111;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_md;
    logic       ex_load;
    logic [4:0] ex_wr_reg;
    logic       ex_md_start;
    logic [1:0] ex_md_op;
    logic       int_req;
  } stim_t;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t  expQ[$];
  stim_t nxt;
  int    checkCount = 0;
  int    errorCount = 0;

  task automatic setIdle();
    nxt = '0;
  endtask

  // Drives nxt just after a rising edge and records the expected control word
  // for that cycle.
  task automatic applyStimulus(input string name, input logic [6:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = nxt.rst;
    id_rs       = nxt.id_rs;
    id_rt       = nxt.id_rt;
    id_use_rs   = nxt.id_use_rs;
    id_use_rt   = nxt.id_use_rt;
    id_md       = nxt.id_md;
    ex_load     = nxt.ex_load;
    ex_wr_reg   = nxt.ex_wr_reg;
    ex_md_start = nxt.ex_md_start;
    ex_md_op    = nxt.ex_md_op;
    int_req     = nxt.int_req;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] act;
    act = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, int_ack, md_busy};
    checkCount++;
    if (act !== e.exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b required %b {pc,ifid_en,idex_en,ifid_fl,idex_fl,ack,busy} @%0t",
               e.name, act, e.exp, $time);
    end
  endtask

`ifdef HAZ_STATS_EN
  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
`endif

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  always @(posedge clk) begin
    if (!rst && md_busy && ex_md_start)
      $error("[TB] ex_md_start issued while md_busy");
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset, including a load-use pattern that reset must mask.
    setIdle(); nxt.rst = 1'b1;
    applyStimulus("reset", RUN);
    nxt.ex_load = 1'b1; nxt.ex_wr_reg = 5'd8; nxt.id_rs = 5'd8; nxt.id_use_rs = 1'b1;
    applyStimulus("reset_masks_hazard", RUN);
    setIdle();
    applyStimulus("idle", RUN);

    // Load-use on rs, then release.
    nxt.ex_load = 1'b1; nxt.ex_wr_reg = 5'd8; nxt.id_rs = 5'd8; nxt.id_use_rs = 1'b1;
    applyStimulus("load_use_rs", STL);
    setIdle(); nxt.id_rs = 5'd8; nxt.id_use_rs = 1'b1;
    applyStimulus("load_use_release", RUN);

    // $zero destination never stalls.
    setIdle(); nxt.ex_load = 1'b1; nxt.ex_wr_reg = 5'd0; nxt.id_rs = 5'd0; nxt.id_use_rs = 1'b1;
    applyStimulus("load_use_r0", RUN);

    // rt path, and rt match without a read.
    setIdle(); nxt.ex_load = 1'b1; nxt.ex_wr_reg = 5'd5; nxt.id_rt = 5'd5; nxt.id_use_rt = 1'b1;
    applyStimulus("load_use_rt", STL);
    nxt.id_use_rt = 1'b0;
    applyStimulus("load_rt_not_used", RUN);

    // Mult start with dependent mflo in ID: 1 + 5 stalled cycles, then issue.
    setIdle(); nxt.ex_md_start = 1'b1; nxt.ex_md_op = MD_MULT; nxt.id_md = 1'b1;
    applyStimulus("mult_start_stall", STL);
    setIdle(); nxt.id_md = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus("mult_busy_stall", STLB);
    applyStimulus("mflo_issue", RUN);
    setIdle();
    applyStimulus("after_mult", RUN);

    // Div with an interrupt at busy cycle 3, int_req held 4 cycles.
    setIdle(); nxt.ex_md_start = 1'b1; nxt.ex_md_op = MD_DIV;
    applyStimulus("div_start", RUN);
    setIdle();
    applyStimulus("div_busy1", RUNB);
    applyStimulus("div_busy2", RUNB);
    nxt.int_req = 1'b1;
    applyStimulus("div_int_ack", ACKB);
    for (int i = 0; i < 3; i++) applyStimulus("int_held_no_reack", RUNB);
    setIdle();
    for (int i = 0; i < 4; i++) applyStimulus("div_busy_tail", RUNB);
    applyStimulus("div_done", RUN);

    // Interrupt during a load-use stall overrides it.
    setIdle(); nxt.ex_load = 1'b1; nxt.ex_wr_reg = 5'd8; nxt.id_rs = 5'd8; nxt.id_use_rs = 1'b1;
    nxt.int_req = 1'b1;
`ifdef HAZ_STATS_EN
    applyStimulus("int_over_load_stall", ACK);
    snapA = flush_cnt;
`else
    applyStimulus("int_over_load_stall", ACK);
`endif
    nxt.int_req = 1'b0;
    applyStimulus("load_stall_after_int", STL);
    setIdle();
    applyStimulus("load_release_after_int", RUN);

    // Re-arm: a fresh request after a low cycle is taken again.
    nxt.int_req = 1'b1;
    applyStimulus("int_second_ack", ACK);
    applyStimulus("int_second_held", RUN);
    nxt.int_req = 1'b0;
    applyStimulus("int_low", RUN);
    nxt.int_req = 1'b1;
    applyStimulus("int_third_ack", ACK);
    setIdle();
    applyStimulus("int_release", RUN);
`ifdef HAZ_STATS_EN
    checkValue("flush_cnt_delta", flush_cnt - snapA, 32'd3);
`endif

    // Div with dependent mfhi: 11 stalled cycles.
    setIdle(); nxt.ex_md_start = 1'b1; nxt.ex_md_op = MD_DIVU; nxt.id_md = 1'b1;
    applyStimulus("div_start_stall", STL);
`ifdef HAZ_STATS_EN
    snapB = stall_cnt;
`endif
    setIdle(); nxt.id_md = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus("div_busy_stall", STLB);
    applyStimulus("mfhi_issue", RUN);
`ifdef HAZ_STATS_EN
    checkValue("stall_cnt_div", stall_cnt - snapB, 32'd11);
`endif

    // Reset in the middle of a multu.
    setIdle(); nxt.ex_md_start = 1'b1; nxt.ex_md_op = MD_MULTU;
    applyStimulus("multu_start", RUN);
    setIdle();
    applyStimulus("multu_busy1", RUNB);
    applyStimulus("multu_busy2", RUNB);
    nxt.rst = 1'b1; nxt.id_md = 1'b1; nxt.int_req = 1'b1;
    applyStimulus("reset_mid_busy", RUN);
    setIdle(); nxt.id_md = 1'b1;
    applyStimulus("idle_after_reset", RUN);
`ifdef HAZ_STATS_EN
    applyStimulus("stats_cleared_cycle", RUN);
    checkValue("stall_cnt_reset", stall_cnt, 32'd0);
    checkValue("flush_cnt_reset", flush_cnt, 32'd0);
`endif
    setIdle();
    applyStimulus("final_idle", RUN);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (expQ.size() > 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the five-stage MIPS core. It computes, every cycle, the enable and flush controls for PC, IF/ID and ID/EX: load-use stalls, multiply/divide busy stalls and interrupt flushes. It also owns the HI/LO unit busy counter. It sits beside the decode stage, and its `id_ex_en` / `id_ex_flush` outputs drive the ID/EX register's `en` and `IntBeq` inputs.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, 10: busy cycles after a div/divu start.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `id_rs` / `id_rt`, in, 5 each: source register numbers in ID.
- `id_use_rs` / `id_use_rt`, in, 1 each: ID instruction reads rs / rt.
- `id_md`, in, 1: ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `ex_load`, in, 1: EX instruction is a load.
- `ex_wr_reg`, in, 5: EX destination register.
- `ex_md_start`, in, 1: EX instruction starts the mult/div unit.
- `ex_md_op`, in, 2: 00 mult, 01 multu, 10 div, 11 divu.
- `int_req`, in, 1: level interrupt request from CP0.
- `pc_en`, out, 1: PC update enable.
- `if_id_en`, out, 1: IF/ID hold when 0.
- `if_id_flush`, out, 1: IF/ID clear.
- `id_ex_en`, out, 1: 0 inserts a bubble into ID/EX.
- `id_ex_flush`, out, 1: ID/EX clear.
- `int_ack`, out, 1: one-cycle pulse when an interrupt is accepted.
- `md_busy`, out, 1: mult/div unit occupied.

## Operation
- `load_stall` = `ex_load` & (`ex_wr_reg` ≠ 0) & ((`id_use_rs` & `id_rs` == `ex_wr_reg`) | (`id_use_rt` & `id_rt` == `ex_wr_reg`)).
- `md_stall` = `id_md` & (`md_busy` | `ex_md_start`).
- `stall` = `load_stall` | `md_stall`. A stall drives `pc_en`=0, `if_id_en`=0 and `id_ex_en`=0 (bubble).
- Mult/div FSM states:
  - IDLE: `ex_md_start` loads `cnt` with `MULT_CYCLES`-1 when `ex_md_op[1]`=0, else `DIV_CYCLES`-1, then goes to BUSY.
  - BUSY: `cnt` decrements each cycle. `cnt`==0 returns to IDLE. `md_busy` = (state==BUSY).
  - `ex_md_start` while BUSY is ignored. The stall makes it unreachable; a bench assertion flags it.
- Interrupt:
  - Accept condition: `int_req` & !`int_pend`. On accept, the same cycle drives `int_ack`=1, `if_id_flush`=1 and `id_ex_flush`=1; `pc_en`=1 so the PC loads the vector.
  - `int_pend` sets on accept and clears on the first cycle `int_req`=0.
  - A held `int_req` is taken once.
- Priority: `rst` > interrupt accept > stall. An accepted interrupt overrides stall, so enables are 1 and flushes are 1.
- The interrupt does not abort the mult/div FSM: `cnt` keeps counting and `md_busy` stays valid.

## Timing
- `stall`, flushes and `int_ack` are combinational from inputs and registered state, so they take effect at the next clock edge.
- The `cnt` load happens at the edge ending the `ex_md_start` cycle.
- `md_busy` is high for exactly `MULT_CYCLES` / `DIV_CYCLES` cycles after that edge.
- A dependent mfhi/mflo stalls through the last busy cycle and issues in the first cycle with `md_busy`=0.
- Reset values:
  - Registered state: state=IDLE, `cnt`=0, `int_pend`=0.
  - Outputs during reset: `pc_en`=1, `if_id_en`=1, `id_ex_en`=1, all flushes 0, `int_ack`=0, `md_busy`=0.
- Reset mid-BUSY returns to IDLE next cycle.

## Configuration
- `HAZ_STATS_EN` defined: adds outputs `stall_cnt` [31:0] and `flush_cnt` [31:0].
  - `stall_cnt` increments each cycle `stall` & !`int_ack`.
  - `flush_cnt` increments on each `int_ack`.
  - Both wrap at 2^32 and are cleared by `rst`.
- `HAZ_STATS_EN` undefined: the ports and counters are absent.

## Structure
- The shared package `cpu_pkg` holds:
  - the `ex_md_op` encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the FSM state typedef `md_state_t` (IDLE, BUSY);
  - the default latency constants.
- One sub-module, `md_busy_ctr`, contains the counter/FSM and exposes `md_busy`. The hazard equations stay in the top.

## Test plan
- Load-use: `ex_load`=1, `ex_wr_reg`=8; ID `id_rs`=8, `id_use_rs`=1 -> one cycle of `pc_en`=`if_id_en`=`id_ex_en`=0, released next cycle. Same with `ex_wr_reg`=0 -> no stall.
- Mult busy: `ex_md_start`, op=00, then mflo in ID -> `md_busy` high 5 cycles, mflo stalled 6 cycles including the start cycle.
- Div busy: op=10 -> `md_busy` high exactly 10 cycles, `stall_cnt` += 11 with `HAZ_STATS_EN`.
- Interrupt during a load-use stall -> `int_ack`=1, both flushes 1, `pc_en`=1. `int_req` held 4 cycles -> only one `int_ack`.
- Interrupt at cycle 3 of a div -> `md_busy` continues and drops after 10 total cycles.
- `rst` asserted mid-BUSY -> `md_busy`=0 next cycle, outputs at their reset values.
